// File: rtl/multicycle_ctrl_if.sv
// Control bundle between multicycle_ctrl and the multi-cycle datapath / unified memory.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned CNT_W   = 16
);
    logic [OP_W-1:0]    instr_op_i;
    logic               mem_ready_i;
    logic               pc_write_o;
    logic               pc_write_cond_o;
    logic [1:0]         pc_src_o;
    logic               ir_write_o;
    logic               mem_req_o;
    logic               mem_we_o;
    logic               iord_o;
    logic               reg_write_o;
    logic               reg_dst_o;
    logic               mem_to_reg_o;
    logic               alu_src_a_o;
    logic [1:0]         alu_src_b_o;
    logic [ALUOP_W-1:0] alu_op_o;
    logic [3:0]         state_o;
    logic [CNT_W-1:0]   instr_cnt_o;

    modport master (
        input  instr_op_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o, mem_req_o, mem_we_o,
               iord_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, state_o, instr_cnt_o
    );

    modport slave (
        output instr_op_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o, mem_req_o, mem_we_o,
               iord_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, state_o, instr_cnt_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with memory handshake
// and retired-instruction counter. Define MULTICYCLE_CTRL_TRAP_EN to make ILLEGAL terminal.
module multicycle_ctrl #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master bus
);
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'h0A);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_ADDI  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLTI  = ALUOP_W'(4);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_ADDI = 4'd3,
        EXEC_SLTI = 4'd4,
        WB_R      = 4'd5,
        WB_I      = 4'd6,
        BRANCH    = 4'd7,
        JUMP      = 4'd8,
        MEM_ADDR  = 4'd9,
        MEM_RD    = 4'd10,
        MEM_WB    = 4'd11,
        MEM_WR    = 4'd12,
        ILLEGAL   = 4'd13
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               retire;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_src;
    logic               ir_write;
    logic               mem_req;
    logic               mem_we;
    logic               iord;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;

    // State register and retired-instruction counter; reset abandons any partial instruction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (retire) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and control decode from the current state.
    always_comb begin
        state_nx      = state;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        ir_write      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = ALU_ADD;

        unique case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = bus.mem_ready_i;
                pc_write  = bus.mem_ready_i;
                if (bus.mem_ready_i) state_nx = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'd3;
                if      (bus.instr_op_i == OP_RTYPE) state_nx = EXEC_R;
                else if (bus.instr_op_i == OP_ADDI)  state_nx = EXEC_ADDI;
                else if (bus.instr_op_i == OP_SLTI)  state_nx = EXEC_SLTI;
                else if (bus.instr_op_i == OP_BEQ)   state_nx = BRANCH;
                else if (bus.instr_op_i == OP_LW ||
                         bus.instr_op_i == OP_SW)    state_nx = MEM_ADDR;
                else if (bus.instr_op_i == OP_J)     state_nx = JUMP;
                else                                 state_nx = ILLEGAL;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_nx  = WB_R;
            end
            EXEC_ADDI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_ADDI;
                state_nx  = WB_I;
            end
            EXEC_SLTI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_SLTI;
                state_nx  = WB_I;
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_nx  = FETCH;
            end
            WB_I: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_nx  = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
                retire        = 1'b1;
                state_nx      = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_nx  = (bus.instr_op_i == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready_i) state_nx = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_nx   = FETCH;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready_i) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                end
            end
            ILLEGAL: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                state_nx = ILLEGAL;
`else
                retire   = 1'b1;
                state_nx = FETCH;
`endif
            end
            default: state_nx = FETCH;
        endcase

        // Held reset presents the FETCH address/ALU selects with every strobe quiet.
        if (rst_i) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_src        = 2'd0;
            ir_write      = 1'b0;
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            iord          = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'd1;
            alu_op        = ALU_ADD;
        end
    end

    assign bus.pc_write_o      = pc_write;
    assign bus.pc_write_cond_o = pc_write_cond;
    assign bus.pc_src_o        = pc_src;
    assign bus.ir_write_o      = ir_write;
    assign bus.mem_req_o       = mem_req;
    assign bus.mem_we_o        = mem_we;
    assign bus.iord_o          = iord;
    assign bus.reg_write_o     = reg_write;
    assign bus.reg_dst_o       = reg_dst;
    assign bus.mem_to_reg_o    = mem_to_reg;
    assign bus.alu_src_a_o     = alu_src_a;
    assign bus.alu_src_b_o     = alu_src_b;
    assign bus.alu_op_o        = alu_op;
    assign bus.state_o         = 4'(state);
    assign bus.instr_cnt_o     = cnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and randomized instruction streams
// checked against a per-instruction phase/event model.
module tb_multicycle_ctrl;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned CNT_W   = 4;

`ifdef MULTICYCLE_CTRL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam int C_R = 0, C_ADDI = 1, C_SLTI = 2, C_BEQ = 3, C_LW = 4, C_SW = 5, C_J = 6, C_ILL = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();
    multicycle_ctrl #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed control word: pc_write, pc_write_cond, pc_src, ir_write, mem_req, mem_we, iord,
    // reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op (MSB to LSB).
    function automatic logic [31:0] ctl();
        return {15'b0, bus.pc_write_o, bus.pc_write_cond_o, bus.pc_src_o, bus.ir_write_o,
                bus.mem_req_o, bus.mem_we_o, bus.iord_o, bus.reg_write_o, bus.reg_dst_o,
                bus.mem_to_reg_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o};
    endfunction

    function automatic logic [5:0] op_of(input int c);
        case (c)
            C_R:    return 6'h00;
            C_ADDI: return 6'h08;
            C_SLTI: return 6'h0A;
            C_BEQ:  return 6'h04;
            C_LW:   return 6'h23;
            C_SW:   return 6'h2B;
            C_J:    return 6'h02;
            default: return ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h11;
        endcase
    endfunction

    // One clock: advance, drive inputs 1ns after the edge, sample 1ns later.
    task automatic cyc(input logic rdy, input logic [5:0] op);
        @(posedge clk);
        #1;
        bus.mem_ready_i = rdy;
        bus.instr_op_i  = op;
        #1;
    endtask

    task automatic bump_cnt();
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    // Runs one instruction with fw fetch wait cycles and mw memory wait cycles.
    task automatic run_instr(input int c, input int fw, input int mw);
        logic [5:0] op;
        int st[$];
        int mem_start;
        int n_rw, n_mreq, n_we, n_ir, n_pcw, n_pcc;
        bit in_fetch, in_mem, is_mem;
        logic rdy;
        op = op_of(c);
        is_mem = (c == C_LW) || (c == C_SW);
        mem_start = fw + 3;
        n_rw = 0; n_mreq = 0; n_we = 0; n_ir = 0; n_pcw = 0; n_pcc = 0;
        for (int i = 0; i <= fw; i++) st.push_back(0);
        st.push_back(1);
        case (c)
            C_R:    begin st.push_back(2); st.push_back(5); end
            C_ADDI: begin st.push_back(3); st.push_back(6); end
            C_SLTI: begin st.push_back(4); st.push_back(6); end
            C_BEQ:  st.push_back(7);
            C_J:    st.push_back(8);
            C_LW:   begin st.push_back(9); for (int i = 0; i <= mw; i++) st.push_back(10); st.push_back(11); end
            C_SW:   begin st.push_back(9); for (int i = 0; i <= mw; i++) st.push_back(12); end
            default: st.push_back(13);
        endcase

        for (int i = 0; i < st.size(); i++) begin
            in_fetch = (i <= fw);
            in_mem   = is_mem && (i >= mem_start) && (i <= mem_start + mw);
            if (in_fetch)    rdy = (i == fw);
            else if (in_mem) rdy = (i == mem_start + mw);
            else             rdy = 1'($urandom_range(0, 1));
            cyc(rdy, in_fetch ? 6'($urandom) : op);
            if (i == 0) check("cnt_at_fetch", 32'(bus.instr_cnt_o), 32'(exp_cnt));
            check("state", 32'(bus.state_o), 32'(st[i]));
            if (bus.reg_write_o) begin
                n_rw++;
                check("reg_dst", 32'(bus.reg_dst_o), 32'(c == C_R));
                check("mem_to_reg", 32'(bus.mem_to_reg_o), 32'(c == C_LW));
            end
            if (bus.mem_req_o) begin
                n_mreq++;
                check("iord", 32'(bus.iord_o), 32'(!in_fetch));
                check("mem_we", 32'(bus.mem_we_o), 32'(!in_fetch && c == C_SW));
            end
            if (bus.mem_we_o) n_we++;
            if (bus.ir_write_o) begin
                n_ir++;
                check("ir_write_cycle", 32'(i), 32'(fw));
            end
            if (bus.pc_write_o) begin
                n_pcw++;
                check("pc_src_pcw", 32'(bus.pc_src_o), in_fetch ? 32'd0 : 32'd2);
            end
            if (bus.pc_write_cond_o) begin
                n_pcc++;
                check("pc_src_beq", 32'(bus.pc_src_o), 32'd1);
                check("alu_op_beq", 32'(bus.alu_op_o), 32'd1);
            end
            if (i == fw + 1) check("decode_ctl", ctl(), 32'h18);
            if (i == fw + 2) begin
                case (c)
                    C_R:            check("exec_ctl", ctl(), 32'h22);
                    C_ADDI:         check("exec_ctl", ctl(), 32'h33);
                    C_SLTI:         check("exec_ctl", ctl(), 32'h34);
                    C_LW, C_SW:     check("exec_ctl", ctl(), 32'h30);
                    C_BEQ:          check("exec_ctl", ctl(), 32'h0A021);
                    C_J:            check("exec_ctl", ctl(), 32'h14000);
                    default:        check("exec_ctl", ctl(), 32'h0);
                endcase
            end
        end

        check("n_reg_write", 32'(n_rw), 32'(c inside {C_R, C_ADDI, C_SLTI, C_LW}));
        check("n_mem_req", 32'(n_mreq), 32'(fw + 1 + (is_mem ? mw + 1 : 0)));
        check("n_mem_we", 32'(n_we), 32'((c == C_SW) ? mw + 1 : 0));
        check("n_ir_write", 32'(n_ir), 32'd1);
        check("n_pc_write", 32'(n_pcw), 32'(1 + (c == C_J)));
        check("n_pc_write_cond", 32'(n_pcc), 32'(c == C_BEQ));
        bump_cnt();
    endtask

    // Spend one FETCH cycle with memory not ready (no progress).
    task automatic idle_fetch(input string tag);
        cyc(1'b0, 6'($urandom));
        check({tag, "_state"}, 32'(bus.state_o), 32'd0);
        check({tag, "_cnt"}, 32'(bus.instr_cnt_o), 32'(exp_cnt));
    endtask

    int c;

    initial begin
        bus.mem_ready_i = 1'b1;
        bus.instr_op_i  = 6'h00;

        // Reset held two cycles with ready high: strobes must stay quiet.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 6'h23);
            check("rst_ctl", ctl(), 32'h8);
        end
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_cnt", 32'(bus.instr_cnt_o), 32'd0);
        #1 rst = 1'b0;
        bus.mem_ready_i = 1'b0;
        exp_cnt = 0;

        // Directed: R, LW with memory wait, BEQ, J, SW with fetch wait, illegal.
        run_instr(C_R, 0, 0);
        run_instr(C_LW, 0, 3);
        run_instr(C_BEQ, 0, 0);
        run_instr(C_J, 0, 0);
        run_instr(C_SW, 2, 0);
        run_instr(C_ADDI, 1, 0);
        run_instr(C_SLTI, 0, 0);
        run_instr(C_SW, 0, 2);
        if (!TRAP) run_instr(C_ILL, 0, 0);
        idle_fetch("after_directed");

        // Randomized instruction mix.
        for (int k = 0; k < 30; k++) begin
            c = $urandom_range(0, TRAP ? 6 : 7);
            run_instr(c, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset during a stalled load read.
        cyc(1'b1, 6'h23);
        cyc(1'b0, 6'h23);
        cyc(1'b0, 6'h23);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 6'h23);
            check("memrd_state", 32'(bus.state_o), 32'd10);
            check("memrd_ctl", ctl(), 32'hA00);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mem_ready_i = 1'b1;
        #1;
        check("abort_ctl", ctl(), 32'h8);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ready_i = 1'b0;
        #1;
        exp_cnt = 0;
        check("abort_state", 32'(bus.state_o), 32'd0);
        check("abort_cnt", 32'(bus.instr_cnt_o), 32'd0);

        // Counter wrap: 15 retires, then one more returns to zero.
        for (int k = 0; k < 15; k++) run_instr($urandom_range(0, 6), 0, $urandom_range(0, 1));
        idle_fetch("cnt15");
        check("cnt_is_15", 32'(bus.instr_cnt_o), 32'd15);
        run_instr(C_J, 0, 0);
        idle_fetch("wrap");
        check("cnt_wrap", 32'(bus.instr_cnt_o), 32'd0);

        // Illegal opcode 0x3F.
        if (TRAP) begin
            run_instr(C_R, 0, 0);
            cyc(1'b1, 6'h00);
            cyc(1'b1, 6'h3F);
            check("ill_decode", 32'(bus.state_o), 32'd1);
            for (int i = 0; i < 10; i++) begin
                cyc(1'($urandom_range(0, 1)), 6'($urandom));
                check("trap_state", 32'(bus.state_o), 32'd13);
                check("trap_ctl", ctl(), 32'h0);
                check("trap_cnt", 32'(bus.instr_cnt_o), 32'(exp_cnt));
            end
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            bus.mem_ready_i = 1'b0;
            #1;
            exp_cnt = 0;
            check("trap_exit_state", 32'(bus.state_o), 32'd0);
            check("trap_exit_cnt", 32'(bus.instr_cnt_o), 32'd0);
        end else begin
            run_instr(C_ILL, 0, 0);
            idle_fetch("ill_nop");
        end
        run_instr(C_LW, 1, 1);
        idle_fetch("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
